// File: rtl/mux_arbiter8_16bit.sv
// mux_arbiter8_16bit: round-robin or fixed-priority 8:1 arbiter feeding a single-entry 16-bit output register.
module mux_arbiter8_16bit #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_req,
    input  logic [15:0] i_in0,
    input  logic [15:0] i_in1,
    input  logic [15:0] i_in2,
    input  logic [15:0] i_in3,
    input  logic [15:0] i_in4,
    input  logic [15:0] i_in5,
    input  logic [15:0] i_in6,
    input  logic [15:0] i_in7,
    output logic [7:0]  o_ack,
    output logic [2:0]  o_sel,
    output logic [15:0] o_y,
    output logic        o_y_valid,
    input  logic        i_y_ready
);
    logic [2:0]  r_ptr;
    logic [2:0]  r_last_sel;
    logic [15:0] r_y;
    logic        r_y_valid;
    logic [2:0]  w_base;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_win;
    logic        w_load;
    logic [15:0] w_in [8];

    assign w_in = '{i_in0, i_in1, i_in2, i_in3, i_in4, i_in5, i_in6, i_in7};

    // Rotate requests so the scan starts at the base; fixed priority scans from 0.
    always_comb begin
        w_base = PRIO_FIXED ? 3'd0 : r_ptr;
        w_rot  = '0;
        for (int i = 0; i < 8; i++) w_rot[i] = i_req[w_base + 3'(i)];
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) if (w_rot[i]) w_off = 3'(i);
        w_win  = w_base + w_off;
        w_load = i_rst_n && (|i_req) && (!r_y_valid || i_y_ready);
    end

    assign o_ack     = w_load ? 8'b1 << w_win : 8'b0;
    assign o_sel     = w_load ? w_win : r_last_sel;
    assign o_y       = r_y;
    assign o_y_valid = r_y_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_ptr      <= '0;
            r_last_sel <= '0;
        end else if (w_load) begin
            r_y        <= w_in[w_win];
            r_y_valid  <= 1'b1;
            r_last_sel <= w_win;
            r_ptr      <= w_win + 3'd1;
        end else if (i_y_ready) begin
            r_y_valid  <= 1'b0;
        end
    end
endmodule

// File: doc/mux_arbiter8_16bit.md
# mux_arbiter8_16bit

Round-robin arbiter and output register that shares an eight-way 16-bit select datapath among eight requesters. Each requester presents a 16-bit word with a `req`/`ack` handshake. The block picks one winner per transfer and drives the mux select. It captures the selected word into a single-entry output register that is drained with a `y_valid`/`y_ready` handshake. It sits between the ALU result sources and the shared 16-bit result bus.

## Interface
- `PRIO_FIXED`, default 0: 0 selects round-robin arbitration; 1 selects fixed priority, where the lowest index wins.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  8  per-requester valid; `req[i]` qualifies `in<i>`.
- `in0`..`in7`  in  16 each  requester data words.
- `ack`  out  8  combinational one-hot grant; `req[i] && ack[i]` in a cycle means `in<i>` is captured at that clock edge.
- `sel`  out  3  mux select: the current winner when loading, otherwise the last winner.
- `y`  out  16  registered output word.
- `y_valid`  out  1  `y` holds an undelivered word.
- `y_ready`  in  1  downstream accepts `y` this cycle.

## Operation
- **Internal datapath:** a 16-bit eight-to-one mux selects `in<sel>`.
- **State:** two states held in `y_valid`.
  - EMPTY: `y_valid`=0.
  - FULL: `y_valid`=1.
- **Load condition:** `load = |req && (!y_valid || y_ready)`.
- **Round-robin winner:** the first `i` with `req[i]`=1, scanning `ptr`, `ptr+1`, … `ptr+7` mod 8.
- **Fixed-priority winner:** the lowest `i` with `req[i]`=1.
- **On load:**
  - `ack[winner]`=1 and all other `ack` bits are 0.
  - At the edge: `y` ← `in<winner>`, `y_valid` ← 1, `last_sel` ← winner, `ptr` ← (winner+1) mod 8.
  - `ptr` wraps from 7 to 0.
- **No load:** `ack`=0. `sel`=`last_sel`.
- **Drain without refill:** when `y_valid && y_ready && !|req`, `y_valid` ← 0 and `y` keeps its old value.
- **Stall:** in FULL with `y_ready`=0, `y`, `y_valid`, `ptr` and `last_sel` all hold. `ack` stays 0 regardless of `req`.
- **Simultaneous drain and refill:** in FULL with `y_ready`=1 and `|req`, the old word is delivered and the new one is loaded in the same cycle. There is no bubble.
- **Requester protocol:**
  - A requester may drop `req` at any time before `ack`.
  - The word must be held stable while `req`=1.
  - After a cycle with `req[i] && ack[i]`, the requester either presents its next word or drops `req`.
- **Reset:** while `rst_n`=0:
  - `ack` is forced to 0 whatever `req` is.
  - At the edge: `y`=16'h0000, `y_valid`=0, `ptr`=0, `last_sel`=0, so `sel`=0.
  - A word held in `y` when reset is asserted is discarded.
- **Fairness:** in round-robin mode, a continuously requesting port is granted within 8 loads.

## Timing
- `ack` and `sel` are combinational from `req`, `y_valid`, `y_ready` and the registered `ptr`/`last_sel`. There is no combinational path from `in*` to any output.
- Latency is 1 cycle: a word acked in cycle N appears on `y` with `y_valid`=1 in cycle N+1.
- Throughput is 1 word per cycle when `y_ready` is held at 1.
- The first cycle after reset release is EMPTY; a request present in that cycle is acked in that cycle.

## Test plan
- **Reset and empty:** hold `rst_n`=0 with `req`=8'hFF. Required: `ack`=0, `y`=0, `y_valid`=0, `sel`=0. Release reset with `req`=8'h00. Required: still idle.
- **Single request:** `req`=8'h10 with `in4`=16'hBEEF. Required: `ack`=8'h10 and `sel`=4 the same cycle; next cycle `y`=16'hBEEF, `y_valid`=1.
- **Round-robin rotation:** `req`=8'hFF held with `y_ready`=1. Required: acks 0,1,…,7,0 on consecutive cycles. Each `y` equals the acked input one cycle later, with no bubbles.
- **Back-pressure:** FULL with `y`=16'h1234 and `y_ready`=0 for 5 cycles while `req`=8'h02. Required: `ack`=0 and `y` stable at 16'h1234. Then raise `y_ready`. Required: `ack`=8'h02 that cycle and the new `y`=`in1` next cycle.
- **Pointer wrap and skip:** after a grant to 6 (`ptr`=7), apply `req`=8'h05. Required: `ack`=8'h01, then `ack`=8'h04 on the next load.
- **Mid-operation reset and fixed priority:** with `PRIO_FIXED`=1 and `req`=8'hA0, required: grant 5 every load. Assert `rst_n`=0 while FULL. Required: `y_valid`=0 and `y`=0 next cycle, and the pending word is lost.
